system_lcd_d_in: RTL and testbench

- Avalon-MM slave input port: the read-side counterpart of the LCD data output PIO. Samples an external WIDTH-bit bus (e.g. LCD D[7:0] read-back, busy flag on bit 7) into the clk domain.
- Detects edges per bit and latches them in a sticky edge-capture register.
- Raises a maskable level interrupt to the CPU.
- Sits on the system interconnect beside the LCD output PIOs.

---
 rtl/system_lcd_d_in.sv | 106 ++++++++++
 tb/tb_system_lcd_d_in.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/system_lcd_d_in.sv
// Avalon-MM input PIO: synchronises an external bus, logs per-bit edges in a
// sticky write-1-to-clear capture register and raises a maskable level irq.
module system_lcd_d_in #(
   parameter int unsigned     WIDTH          = 8,
   parameter int unsigned     EDGE_TYPE      = 0,
   parameter logic [WIDTH-1:0] IRQ_MASK_RESET = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA  = 2'd0;
   localparam logic [1:0] ADDR_MASK  = 2'd2;
   localparam logic [1:0] ADDR_EDGE  = 2'd3;
   localparam logic [1:0] WARM_DONE  = 2'd3;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] irqmask;
   logic [1:0]       warm;

   logic             wr_c;
   logic             wr_mask_c;
   logic             wr_ec_c;
   logic [WIDTH-1:0] wdata_c;
   logic [WIDTH-1:0] rise_c;
   logic [WIDTH-1:0] fall_c;
   logic [WIDTH-1:0] edge_c;
   logic [31:0]      rd_mux_c;
   logic             unused_wdata;

   assign wr_c      = chipselect & ~write_n;
   assign wr_mask_c = wr_c && (address == ADDR_MASK);
   assign wr_ec_c   = wr_c && (address == ADDR_EDGE);
   assign wdata_c   = writedata[WIDTH-1:0];
   assign unused_wdata = ^writedata;

   // Edge detect, gated off until the synchroniser pipeline holds real data
   always_comb begin
      rise_c = sync2 & ~prev;
      fall_c = ~sync2 & prev;
      edge_c = '0;
      if (warm == WARM_DONE) begin
         case (EDGE_TYPE)
            0:       edge_c = rise_c;
            1:       edge_c = fall_c;
            default: edge_c = rise_c | fall_c;
         endcase
      end
   end

   always_comb begin
      rd_mux_c = '0;
      case (address)
         ADDR_DATA: rd_mux_c = 32'(sync2);
         ADDR_MASK: rd_mux_c = 32'(irqmask);
         ADDR_EDGE: rd_mux_c = 32'(edgecapture);
         default:   rd_mux_c = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
         warm  <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
         prev  <= sync2;
         if (warm != WARM_DONE) warm <= warm + 2'd1;
      end
   end

   // A new edge beats a simultaneous clear on the same bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edgecapture <= '0;
         irqmask     <= IRQ_MASK_RESET;
      end else begin
         edgecapture <= edge_c | (edgecapture & ~(wr_ec_c ? wdata_c : '0));
         if (wr_mask_c) irqmask <= wdata_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         readdata <= chipselect ? rd_mux_c : '0;
         irq      <= |(edgecapture & irqmask);
      end
   end

endmodule

// File: tb/tb_system_lcd_d_in.sv
// Directed bench for system_lcd_d_in: three instances (rising, falling, any edge)
// share one bus; each step checks hand-computed values with immediate assertions.
module tb_system_lcd_d_in;

   logic        clk;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;

   int n_asrt = 0;
   int n_fail = 0;

   system_lcd_d_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_MASK_RESET(8'h00)) u_e0 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd0), .irq(irq0));

   system_lcd_d_in #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_MASK_RESET(8'h00)) u_e1 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd1), .irq(irq1));

   system_lcd_d_in #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_MASK_RESET(8'h3C)) u_e2 (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(rd2), .irq(irq2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd_reg(input logic [1:0] a);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      tick();
      chipselect = 1'b0;
   endtask

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = 8'hFF;

      // 1: bus high through reset release must not log an edge
      repeat (3) tick();
      chk("rst_readdata", rd0, 32'h0);
      chk("rst_irq", 32'(irq0), 32'h0);
      reset = 1'b0;
      repeat (10) tick();
      chk("warm_ec0", 32'(u_e0.edgecapture), 32'h0);
      chk("warm_ec2", 32'(u_e2.edgecapture), 32'h0);
      chk("warm_irq0", 32'(irq0), 32'h0);
      rd_reg(2'd3);
      chk("warm_rd_ec", rd0, 32'h0);
      rd_reg(2'd0);
      chk("data_ff_e0", rd0, 32'h000000FF);
      chk("data_ff_e2", rd2, 32'h000000FF);
      rd_reg(2'd2);
      chk("mask_rst_e0", rd0, 32'h0);
      chk("mask_rst_e2", rd2, 32'h3C);

      // 2: rising edge on bit 7 -> capture 3 cycles later, irq 1 cycle after
      wr_reg(2'd2, 32'h80);
      in_port = 8'h7F;
      repeat (5) tick();
      chk("fall7_irq1", 32'(irq1), 32'h1);
      wr_reg(2'd3, 32'hFF);
      repeat (2) tick();
      chk("clr_irq1", 32'(irq1), 32'h0);
      in_port = 8'hFF;
      tick(); tick();
      chk("rise7_c2", 32'(u_e0.edgecapture), 32'h0);
      tick();
      chk("rise7_c3", 32'(u_e0.edgecapture), 32'h80);
      chk("rise7_irq_c3", 32'(irq0), 32'h0);
      tick();
      chk("rise7_irq_c4", 32'(irq0), 32'h1);
      rd_reg(2'd3);
      chk("rise7_rd", rd0, 32'h80);
      wr_reg(2'd3, 32'h80);
      chk("w1c_ec", 32'(u_e0.edgecapture), 32'h0);
      tick();
      chk("w1c_irq", 32'(irq0), 32'h0);

      // 3: capture with mask 0, then unmask
      wr_reg(2'd2, 32'h00);
      in_port = 8'hFE; repeat (4) tick();
      in_port = 8'hFF; repeat (4) tick();
      rd_reg(2'd3);
      chk("masked_ec", rd0, 32'h01);
      chk("masked_irq", 32'(irq0), 32'h0);
      wr_reg(2'd2, 32'h01);
      chk("unmask_irq_c1", 32'(irq0), 32'h0);
      tick();
      chk("unmask_irq_c2", 32'(irq0), 32'h1);

      // 4: clear colliding with a new edge on bit 0; then a plain clear
      in_port = 8'hFE; repeat (4) tick();
      in_port = 8'hFF; tick(); tick();
      wr_reg(2'd3, 32'h01);
      chk("coll_ec", 32'(u_e0.edgecapture), 32'h01);
      tick();
      chk("coll_irq", 32'(irq0), 32'h1);
      wr_reg(2'd3, 32'h01);
      chk("preclr_rd", rd0, 32'h01);
      chk("postclr_ec", 32'(u_e0.edgecapture), 32'h0);
      tick();
      chk("postclr_irq", 32'(irq0), 32'h0);

      // 5: any-edge sensitivity and ignored writes to data/reserved
      wr_reg(2'd3, 32'hFF);
      in_port = 8'h00; repeat (5) tick();
      wr_reg(2'd3, 32'hFF);
      tick();
      in_port = 8'h0F; repeat (5) tick();
      rd_reg(2'd3);
      chk("any_up_e2", rd2, 32'h0F);
      chk("any_up_e0", rd0, 32'h0F);
      chk("any_up_e1", rd1, 32'h00);
      in_port = 8'h00; repeat (5) tick();
      rd_reg(2'd3);
      chk("any_dn_e2", rd2, 32'h0F);
      chk("any_dn_e1", rd1, 32'h0F);
      wr_reg(2'd3, 32'hFF);
      rd_reg(2'd3);
      chk("any_clr_e2", rd2, 32'h0);
      in_port = 8'h3C; repeat (4) tick();
      wr_reg(2'd0, 32'hAA);
      wr_reg(2'd1, 32'h55);
      rd_reg(2'd0);
      chk("data_wr_ign", rd2, 32'h3C);
      rd_reg(2'd1);
      chk("resv_rd0", rd2, 32'h0);
      tick();
      chk("nocs_rd0", rd0, 32'h0);

      // 6: asynchronous reset with capture pending, then warm-up
      wr_reg(2'd3, 32'hFF);
      in_port = 8'h00; repeat (4) tick();
      wr_reg(2'd3, 32'hFF);
      in_port = 8'h55; repeat (4) tick();
      chk("pre_rst_irq", 32'(irq0), 32'h1);
      chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
      tick();
      chk("pre_rst_rd", rd0, 32'h55);
      reset = 1'b1;
      #1;
      chk("arst_ec", 32'(u_e0.edgecapture), 32'h0);
      chk("arst_rd", rd0, 32'h0);
      chk("arst_irq", 32'(irq0), 32'h0);
      chk("arst_mask_e0", 32'(u_e0.irqmask), 32'h00);
      chk("arst_mask_e2", 32'(u_e2.irqmask), 32'h3C);
      chipselect = 1'b0;
      tick();
      reset = 1'b0;
      in_port = 8'hFF;
      repeat (6) tick();
      rd_reg(2'd3);
      chk("warm2_e0", rd0, 32'h0);
      chk("warm2_e1", rd1, 32'h0);
      chk("warm2_e2", rd2, 32'h0);
      in_port = 8'h00; repeat (4) tick();
      in_port = 8'hFF; repeat (4) tick();
      rd_reg(2'd3);
      chk("live_e0", rd0, 32'hFF);
      chk("live_e1", rd1, 32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
